// File: rtl/sll_pipe_pkg.sv
// Shared constants, types and the per-stage shift helper for the sll_pipe
// pipelined left shifter.
package sll_pipe_pkg;

  localparam int SLL_DATA_W     = 32;
  localparam int SLL_SHAMT_W    = 5;
  localparam int SLL_NUM_STAGES = 5;

  typedef logic [SLL_DATA_W-1:0]  sll_data_t;
  typedef logic [SLL_SHAMT_W-1:0] sll_shamt_t;

  // Fixed-distance step; bits pushed past the MSB either drop or wrap to bit 0.
  function automatic sll_data_t sll_step(input sll_data_t d, input int unsigned amt,
                                         input logic rot);
    sll_data_t fill;
    sll_data_t wrap;
    fill = d << amt;
    wrap = d >> (SLL_DATA_W - amt);
    return rot ? (fill | wrap) : fill;
  endfunction

endpackage

// File: rtl/sll_pipe_if.sv
// Valid/ready bundle for sll_pipe: operand side, result side and busy.
// The in_rot signal exists only when SLL_PIPE_ROTATE_EN is defined.
interface sll_pipe_if #(
  parameter int TAG_W = 5
);
  import sll_pipe_pkg::*;

  logic             in_valid;
  logic             in_ready;
  sll_data_t        in_data;
  sll_shamt_t       in_shamt;
  logic [TAG_W-1:0] in_tag;
`ifdef SLL_PIPE_ROTATE_EN
  logic             in_rot;
`endif
  logic             out_valid;
  logic             out_ready;
  sll_data_t        out_data;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  modport master (
    output in_valid, in_data, in_shamt, in_tag,
`ifdef SLL_PIPE_ROTATE_EN
    output in_rot,
`endif
    output out_ready,
    input  in_ready, out_valid, out_data, out_tag, busy
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_tag,
`ifdef SLL_PIPE_ROTATE_EN
    input  in_rot,
`endif
    input  out_ready,
    output in_ready, out_valid, out_data, out_tag, busy
  );

endinterface

// File: rtl/sll_pipe_stage.sv
// One registered shifter stage: applies SHIFT when its shamt bit is set.
// With SLL_PIPE_ROTATE_EN defined a rot bit travels along and selects rotate.
module sll_pipe_stage
  import sll_pipe_pkg::*;
#(
  parameter int unsigned SHIFT = 1,
  parameter int          TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             up_valid,
  input  sll_data_t        up_data,
  input  sll_shamt_t       up_shamt,
`ifdef SLL_PIPE_ROTATE_EN
  input  logic             up_rot,
  output logic             q_rot,
`endif
  input  logic [TAG_W-1:0] up_tag,
  input  logic             dn_ready,
  output logic             rdy,
  output logic             q_valid,
  output sll_data_t        q_data,
  output sll_shamt_t       q_shamt,
  output logic [TAG_W-1:0] q_tag
);

  localparam int unsigned SEL = $clog2(SHIFT);

  logic      rot_sel;
  sll_data_t d_next;

`ifdef SLL_PIPE_ROTATE_EN
  assign rot_sel = up_rot;
`else
  assign rot_sel = 1'b0;
`endif

  always_comb begin
    d_next = up_data;
    if (up_shamt[SEL]) begin
      d_next = sll_step(up_data, SHIFT, rot_sel);
    end
  end

  // An empty stage always accepts, so bubbles close up under back-pressure.
  assign rdy = ~q_valid | dn_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      q_valid <= 1'b0;
      q_data  <= '0;
      q_shamt <= '0;
      q_tag   <= '0;
`ifdef SLL_PIPE_ROTATE_EN
      q_rot   <= 1'b0;
`endif
    end else if (rdy) begin
      q_valid <= up_valid;
      if (up_valid) begin
        q_data  <= d_next;
        q_shamt <= up_shamt;
        q_tag   <= up_tag;
`ifdef SLL_PIPE_ROTATE_EN
        q_rot   <= up_rot;
`endif
      end
    end
  end

endmodule

// File: rtl/sll_pipe.sv
// Five-stage elastic 32-bit logical left shifter with tag sideband.
// Define SLL_PIPE_ROTATE_EN to add the in_rot rotate-left option.
module sll_pipe
  import sll_pipe_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input logic       clock,
  input logic       reset,
  sll_pipe_if.slave bus
);

  localparam int NS = SLL_NUM_STAGES;

  // Index 0 is the input port, index k+1 is the output of stage k.
  logic             v_c     [NS+1];
  sll_data_t        data_c  [NS+1];
  sll_shamt_t       shamt_c [NS+1];
  logic [TAG_W-1:0] tag_c   [NS+1];
`ifdef SLL_PIPE_ROTATE_EN
  logic             rot_c   [NS+1];
`endif

  assign v_c[0]     = bus.in_valid;
  assign data_c[0]  = bus.in_data;
  assign shamt_c[0] = bus.in_shamt;
  assign tag_c[0]   = bus.in_tag;
`ifdef SLL_PIPE_ROTATE_EN
  assign rot_c[0]   = bus.in_rot;
`endif

  // Ready is kept per generate scope so the chain never feeds back through one array.
  for (genvar k = 0; k < NS; k++) begin : g_stage
    logic dn_rdy;
    logic rdy;

    if (k == NS - 1) begin : g_tail
      assign dn_rdy = bus.out_ready;
    end else begin : g_link
      assign dn_rdy = g_stage[k+1].rdy;
    end

    sll_pipe_stage #(
      .SHIFT (1 << k),
      .TAG_W (TAG_W)
    ) u_stage (
      .clock    (clock),
      .reset    (reset),
      .up_valid (v_c[k]),
      .up_data  (data_c[k]),
      .up_shamt (shamt_c[k]),
`ifdef SLL_PIPE_ROTATE_EN
      .up_rot   (rot_c[k]),
      .q_rot    (rot_c[k+1]),
`endif
      .up_tag   (tag_c[k]),
      .dn_ready (dn_rdy),
      .rdy      (rdy),
      .q_valid  (v_c[k+1]),
      .q_data   (data_c[k+1]),
      .q_shamt  (shamt_c[k+1]),
      .q_tag    (tag_c[k+1])
    );
  end

  assign bus.in_ready  = g_stage[0].rdy;
  assign bus.out_valid = v_c[NS];
  assign bus.out_data  = data_c[NS];
  assign bus.out_tag   = tag_c[NS];

  logic busy_acc;
  always_comb begin
    busy_acc = 1'b0;
    for (int unsigned k = 1; k <= NS; k++) begin
      busy_acc = busy_acc | v_c[k];
    end
  end
  assign bus.busy = busy_acc;

  // Last stage's carried control bits have no consumer past the output.
  logic unused_tail;
`ifdef SLL_PIPE_ROTATE_EN
  assign unused_tail = ^{shamt_c[NS], rot_c[NS]};
`else
  assign unused_tail = ^shamt_c[NS];
`endif

endmodule

// File: tb/tb_sll_pipe.sv
// Scoreboard bench for sll_pipe: directed handshake scenarios plus random traffic.
// Define SLL_PIPE_ROTATE_EN to also exercise the rotate option.
module tb_sll_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sll_pipe_if #(.TAG_W(5)) bus ();

  sll_pipe #(.TAG_W(5)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
  } exp_t;

  exp_t        sb[$];
  int unsigned out_cyc[$];
  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic        cur_rot = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, got, req);
    end
  endfunction

  // Reference: shift of the word, or the upper half of the doubled word for rotate.
  function automatic logic [31:0] ref_sll(input logic [31:0] d, input int unsigned sh,
                                          input logic rt);
    logic [63:0] twice;
    twice = {d, d} << sh;
    return rt ? twice[63:32] : (d << sh);
  endfunction

  // Monitor: a result transfers on the coming edge whenever valid and ready are both high.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      out_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out: got data 0x%08h tag %0d, required no output",
                 bus.out_data, bus.out_tag);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_data", bus.out_data, e.data);
        chk("out_tag", {27'd0, bus.out_tag}, {27'd0, e.tag});
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic [4:0] sh, input logic [4:0] tg,
                      input logic [31:0] req);
    int unsigned w = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_shamt = sh;
    bus.in_tag   = tg;
`ifdef SLL_PIPE_ROTATE_EN
    bus.in_rot   = cur_rot;
`endif
    @(negedge clk);
    while (!bus.in_ready && w < 50) begin
      w++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got in_ready 0 for %0d cycles, required 1", w);
    end else begin
      sb.push_back('{req, tg});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name, input int unsigned budget);
    int unsigned w = 0;
    while (sb.size() != 0 && w < budget) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1;
    chk(name, sb.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion, required $finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        vb [1:8];
    int unsigned lat;
    logic [31:0] hold;
    logic [31:0] d;
    logic [4:0]  sh;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_shamt  = '0;
    bus.in_tag    = '0;
`ifdef SLL_PIPE_ROTATE_EN
    bus.in_rot    = 1'b0;
`endif
    bus.out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 0);
    chk("rst_busy", {31'd0, bus.busy}, 0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 1);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_tag", {27'd0, bus.out_tag}, 0);
    @(posedge clk);
    #1;

    // Single op, latency 5, then valid drops
    bus.out_ready = 1'b1;
    send(32'h0000_0001, 5'd31, 5'd7, 32'h8000_0000);
    bus.in_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      vb[i] = bus.out_valid;
      if (bus.out_valid && lat == 0) lat = i;
    end
    chk("single_latency", lat, 5);
    chk("single_valid_drop", {31'd0, vb[6]}, 0);
    @(posedge clk);
    #1;

    // Back-to-back sustained throughput
    out_cyc.delete();
    send(32'hFFFF_FFFF, 5'd0,  5'd1, 32'hFFFF_FFFF);
    send(32'hFFFF_FFFF, 5'd1,  5'd2, 32'hFFFF_FFFE);
    send(32'hFFFF_FFFF, 5'd4,  5'd3, 32'hFFFF_FFF0);
    send(32'hFFFF_FFFF, 5'd8,  5'd4, 32'hFFFF_FF00);
    send(32'hFFFF_FFFF, 5'd16, 5'd5, 32'hFFFF_0000);
    send(32'hFFFF_FFFF, 5'd31, 5'd6, 32'h8000_0000);
    bus.in_valid = 1'b0;
    wait_drain("b2b_drain", 40);
    chk("b2b_count", out_cyc.size(), 6);
    if (out_cyc.size() == 6) chk("b2b_span", out_cyc[5] - out_cyc[0], 5);

    // Full-pipe stall
    bus.out_ready = 1'b0;
    out_cyc.delete();
    for (int i = 0; i < 5; i++) begin
      d  = 32'hA5C3_0F01 + i;
      sh = 5'(3 * i + 1);
      send(d, sh, 5'(10 + i), ref_sll(d, sh, 1'b0));
    end
    bus.in_valid = 1'b0;
    hold = sb[0].data;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_in_ready", {31'd0, bus.in_ready}, 0);
      chk("stall_out_valid", {31'd0, bus.out_valid}, 1);
      chk("stall_out_data", bus.out_data, hold);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    #1 chk("release_in_ready", {31'd0, bus.in_ready}, 1);
    wait_drain("stall_drain", 40);
    chk("stall_count", out_cyc.size(), 5);
    if (out_cyc.size() == 5) chk("stall_span", out_cyc[4] - out_cyc[0], 4);

    // Bubble collapse under back-pressure
    bus.out_ready = 1'b0;
    out_cyc.delete();
    send(32'h0000_00F0, 5'd4, 5'd20, 32'h0000_0F00);
    idle(3);
    send(32'h0000_0003, 5'd30, 5'd21, 32'hC000_0000);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("bubble_busy", {31'd0, bus.busy}, 1);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    wait_drain("bubble_drain", 20);
    chk("bubble_count", out_cyc.size(), 2);
    if (out_cyc.size() == 2) chk("bubble_adjacent", out_cyc[1] - out_cyc[0], 1);

    // Reset with ops in flight
    send(32'h1111_1111, 5'd1, 5'd1, 32'h2222_2222);
    send(32'h2222_2222, 5'd2, 5'd2, 32'h8888_8888);
    send(32'h3333_3333, 5'd3, 5'd3, 32'h9999_9998);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", {31'd0, bus.out_valid}, 0);
    chk("midrst_busy", {31'd0, bus.busy}, 0);
    chk("midrst_in_ready", {31'd0, bus.in_ready}, 1);
    chk("midrst_out_data", bus.out_data, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("midrst_no_stale", {31'd0, bus.out_valid}, 0);
    end
    @(posedge clk);
    #1;

`ifdef SLL_PIPE_ROTATE_EN
    // Rotate option
    cur_rot = 1'b1;
    send(32'h8000_0001, 5'd1, 5'd9, 32'h0000_0003);
    cur_rot = 1'b0;
    send(32'h8000_0001, 5'd1, 5'd10, 32'h0000_0002);
    cur_rot = 1'b1;
    send(32'h1234_5678, 5'd8, 5'd11, 32'h3456_7812);
    cur_rot = 1'b0;
    bus.in_valid = 1'b0;
    wait_drain("rot_drain", 30);
`endif

    // Random traffic with random back-pressure
    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_data   = $urandom;
      bus.in_shamt  = 5'($urandom_range(0, 31));
      bus.in_tag    = 5'($urandom);
`ifdef SLL_PIPE_ROTATE_EN
      cur_rot       = 1'($urandom);
      bus.in_rot    = cur_rot;
`endif
      bus.out_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready)
        sb.push_back('{ref_sll(bus.in_data, int'(bus.in_shamt), cur_rot), bus.in_tag});
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    wait_drain("random_drain", 100);
    @(negedge clk);
    chk("final_busy", {31'd0, bus.busy}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sll_pipe.md
Name: sll_pipe

Overview:
- Pipelined 32-bit logical left shifter; the left-shift counterpart to the ALU's arithmetic-right shift path.
- Sits beside the ALU, fed by the execute stage, for SLL ops that need a registered, stallable path.
- Five register stages; stage k applies a shift of 2^(k-1) when the matching shamt bit is set.
- Valid/ready elastic handshake at both ends; carries a tag (destination register) alongside the data.

Parameters:
- TAG_W, 5, width of the sideband tag carried with each operation (destination register index).

Ports:
- clock  input  1  single clock, rising edge
- reset  input  1  synchronous, active-high
- in_valid  input  1  operation present on in_*
- in_ready  output  1  pipeline can accept this cycle
- in_data  input  32  operand
- in_shamt  input  5  shift amount 0..31
- in_tag  input  TAG_W  sideband, passed through unchanged
- out_valid  output  1  result present on out_*
- out_ready  input  1  consumer accepts result this cycle
- out_data  output  32  shifted result
- out_tag  output  TAG_W  tag of the result
- busy  output  1  OR of all stage valid bits

Behaviour:
- Stages S1..S5 each hold: valid, data[31:0], residual shamt bits, tag.
- S1 captures in_data shifted by 1 if in_shamt[0].
- Sk (k = 2..5) captures S(k-1).data shifted by 2^(k-1) if bit k-1 of the carried shamt is set.
- Vacated low bits fill with 0; bits shifted past bit 31 are discarded.
- Outputs are driven from S5: out_valid = S5.valid, out_data = S5.data, out_tag = S5.tag.
- Ready chain (combinational):
  - rdy5 = ~S5.valid | out_ready
  - rdyk = ~Sk.valid | rdy(k+1)
  - in_ready = rdy1
- Transfer into Sk happens when rdyk is high.
  - Sk.valid then loads the upstream valid (in_valid for S1).
  - Payload registers load only when the upstream valid is 1; otherwise they hold.
- When rdyk is low, Sk holds all of its fields.
- Latency: accepted in cycle c (in_valid & in_ready) with no stall -> out_valid high in cycle c+5.
- Throughput: 1 op/cycle sustained.
- Back-pressure: out_ready low with all stages full -> in_ready low in the same cycle. No op is lost or duplicated.
- Bubbles collapse: an empty stage always accepts, even when downstream is stalled.
- Simultaneous events: with S5 full and out_ready = 1 while a new op arrives, the pipeline advances in one cycle; S5 drains and S1 loads.
- shamt = 0: data passes unchanged with the same 5-cycle latency.
- Reset: synchronous.
  - All valid bits go to 0, so out_valid = 0, busy = 0 and in_ready = 1 in the cycle after reset.
  - Data and tag registers reset to 0.
  - Reset mid-operation discards every in-flight op; none appear at the output afterwards.
- Data and tag are never X at the outputs after reset.

Optional Feature:
- Macro: SLL_PIPE_ROTATE_EN
- Defined:
  - Adds port in_rot (input, 1); the rot bit is carried per stage like shamt.
  - When rot = 1, each stage rotates left: bits leaving bit 31 re-enter at bit 0.
  - Result equals rotate-left of in_data by in_shamt.
- Undefined: the port is absent; zero-fill shift only.
- Latency and handshake are identical in both builds.

Decomposition:
- Shared header/package sll_pipe_pkg with constants:
  - SLL_DATA_W = 32
  - SLL_SHAMT_W = 5
  - SLL_NUM_STAGES = 5
- Sub-module sll_pipe_stage: one registered stage.
  - Parameter SHIFT (1, 2, 4, 8, 16) and TAG_W.
  - Ports: upstream valid/data/shamt/tag, downstream ready in, ready out, registered outputs.
  - Instantiated 5 times in a generate loop.
- Top level wires the ready chain and busy.

Test Plan:
- Single op: in_data = 0x00000001, shamt = 31, tag = 7, out_ready = 1 -> cycle c+5: out_valid = 1, out_data = 0x80000000, out_tag = 7; out_valid = 0 on the next cycle.
- Back-to-back: 6 consecutive ops with in_data 0xFFFFFFFF and shamt 0, 1, 4, 8, 16, 31 -> outputs in order on consecutive cycles: 0xFFFFFFFF, 0xFFFFFFFE, 0xFFFFFFF0, 0xFFFFFF00, 0xFFFF0000, 0x80000000.
- Stall: fill the pipe with 5 ops, hold out_ready = 0 for 10 cycles -> in_ready = 0 and out_data stable throughout; release -> all 5 ops drain in order with no loss or duplication; in_ready rises in the same cycle as out_ready.
- Bubble collapse: one op, then 3 idle cycles, then one op, with out_ready = 0 -> the second op advances until it sits directly behind the first; busy = 1 throughout.
- Reset mid-flight: 3 ops in flight, assert reset for 1 cycle -> next cycle out_valid = 0, busy = 0, in_ready = 1; no stale outputs over the following 10 cycles.
- ROTATE build: in_data = 0x80000001, shamt = 1, rot = 1 -> 0x00000003; same with rot = 0 -> 0x00000002; 0x12345678 with shamt = 8, rot = 1 -> 0x34567812.
